// File: rtl/rect_pkg.sv
// Shared constants, FSM state type and helper functions for the RECTANGLE-80 key schedule.
package rect_pkg;

  localparam int ROUNDS = 25;
  localparam logic [4:0] RC_INIT = 5'h01;

  // S-box entry x sits at [4*x +: 4]
  localparam logic [63:0] SBOX = 64'h24F8_D30B_97E1_AC56;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX[4*x +: 4];
  endfunction

  function automatic logic [4:0] rc_step(input logic [4:0] rc);
    return {rc[3:0], rc[4] ^ rc[2]};
  endfunction

endpackage

// File: rtl/rect_key_sched_ctrl_if.sv
// Handshake and key-register bus between the key-schedule sequencer and its neighbours.
interface rect_key_sched_ctrl_if;
  logic        i_start;
  logic [79:0] iv_master_key;
  logic [79:0] iv_regkey;
  logic        i_rk_ready;
  logic        o_key_select;
  logic [79:0] ov_key_data1;
  logic [79:0] ov_key_data2;
  logic [63:0] ov_round_key;
  logic [4:0]  ov_round;
  logic        o_rk_valid;
  logic        o_busy;
  logic        o_done;

  modport master (
    input  i_start, iv_master_key, iv_regkey, i_rk_ready,
    output o_key_select, ov_key_data1, ov_key_data2, ov_round_key,
           ov_round, o_rk_valid, o_busy, o_done
  );

  modport slave (
    output i_start, iv_master_key, iv_regkey, i_rk_ready,
    input  o_key_select, ov_key_data1, ov_key_data2, ov_round_key,
           ov_round, o_rk_valid, o_busy, o_done
  );
endinterface

// File: rtl/rect_key_update.sv
// Combinational RECTANGLE-80 next-key function: column S-box on columns 0..3, row mix, rc injection.
module rect_key_update
  import rect_pkg::*;
(
  input  logic [79:0] key,
  input  logic [4:0]  rc,
  output logic [79:0] key_next
);

  logic [15:0] row [5];
  logic [15:0] sub [5];

  always_comb begin
    logic [3:0] col;
    col = '0;
    for (int i = 0; i < 5; i++) begin
      row[i] = key[16*i +: 16];
      sub[i] = key[16*i +: 16];
    end
    // row0 supplies the LSB of each column nibble
    for (int j = 0; j < 4; j++) begin
      col = sbox({row[3][j], row[2][j], row[1][j], row[0][j]});
      sub[0][j] = col[0];
      sub[1][j] = col[1];
      sub[2][j] = col[2];
      sub[3][j] = col[3];
    end
    key_next[15:0]  = ({sub[0][7:0], sub[0][15:8]} ^ sub[1]) ^ {11'b0, rc};
    key_next[31:16] = sub[2];
    key_next[47:32] = sub[3];
    key_next[63:48] = {sub[3][3:0], sub[3][15:4]} ^ sub[4];
    key_next[79:64] = sub[0];
  end

endmodule

// File: rtl/rect_key_sched_ctrl.sv
// RECTANGLE-80 key-schedule sequencer; define RECT_KEY_AUTORUN_EN to ignore i_rk_ready
// and issue one round key per ROUND cycle.
module rect_key_sched_ctrl
  import rect_pkg::*;
(
  input logic                  i_clk,
  input logic                  i_rst,
  rect_key_sched_ctrl_if.master bus
);

  state_t      state, state_nxt;
  logic [4:0]  round;
  logic [4:0]  rc;
  logic [79:0] next_key;
  logic        ready_eff;
  logic        advance;

  rect_key_update u_update (
    .key      (bus.iv_regkey),
    .rc       (rc),
    .key_next (next_key)
  );

`ifdef RECT_KEY_AUTORUN_EN
  assign ready_eff = bus.i_rk_ready | 1'b1;
`else
  assign ready_eff = bus.i_rk_ready;
`endif

  assign bus.ov_key_data1 = bus.iv_master_key;
  assign bus.ov_round_key = bus.iv_regkey[63:0];
  assign bus.ov_round     = round;

  always_comb begin
    state_nxt        = state;
    advance          = 1'b0;
    bus.o_key_select = 1'b1;
    bus.ov_key_data2 = bus.iv_regkey;
    bus.o_rk_valid   = 1'b0;
    bus.o_busy       = 1'b1;
    bus.o_done       = 1'b0;
    case (state)
      IDLE: begin
        bus.o_busy = 1'b0;
        if (bus.i_start) state_nxt = LOAD;
      end
      LOAD: begin
        bus.o_key_select = 1'b0;
        state_nxt        = ROUND;
      end
      ROUND: begin
        bus.o_rk_valid = 1'b1;
        if (ready_eff) begin
          if (round < 5'(ROUNDS)) begin
            bus.ov_key_data2 = next_key;
            advance          = 1'b1;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        bus.o_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // round and rc step on the same edge that captures the updated key
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      round <= '0;
      rc    <= RC_INIT;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        round <= '0;
        rc    <= RC_INIT;
      end else if (advance) begin
        round <= round + 5'd1;
        rc    <= rc_step(rc);
      end
    end
  end

endmodule

// File: tb/tb_rect_key_sched_ctrl.sv
// Self-checking bench for rect_key_sched_ctrl with a behavioural key-schedule reference model.
module tb_rect_key_sched_ctrl;

  logic clk;
  logic rst;
  logic [79:0] regkey;

  rect_key_sched_ctrl_if bus ();

  rect_key_sched_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external key register: not reset, holds through feedback
  always @(posedge clk)
    regkey <= bus.o_key_select ? bus.ov_key_data2 : bus.ov_key_data1;
  assign bus.iv_regkey = regkey;

  int checks = 0;
  int fails  = 0;
  logic [79:0] exp_k [26];
  logic [4:0]  exp_rc [26];
  int sbox_t [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};

  function automatic logic [79:0] ref_update(input logic [79:0] k, input int rcv);
    int r [5];
    int n [5];
    for (int i = 0; i < 5; i++) r[i] = int'(k[16*i +: 16]);
    for (int j = 0; j < 4; j++) begin
      int idx, s;
      idx = 0;
      for (int i = 0; i < 4; i++) idx += ((r[i] >> j) & 1) << i;
      s = sbox_t[idx];
      for (int i = 0; i < 4; i++) r[i] = (r[i] & ~(1 << j)) | (((s >> i) & 1) << j);
    end
    n[0] = ((((r[0] << 8) | (r[0] >> 8)) & 16'hFFFF) ^ r[1]) ^ rcv;
    n[1] = r[2];
    n[2] = r[3];
    n[3] = (((r[3] << 12) | (r[3] >> 4)) & 16'hFFFF) ^ r[4];
    n[4] = r[0];
    ref_update = '0;
    for (int i = 0; i < 5; i++) ref_update[16*i +: 16] = 16'(n[i]);
  endfunction

  task automatic build_expected(input logic [79:0] mk);
    int rcv;
    rcv = 1;
    exp_k[0] = mk;
    for (int n = 0; n < 26; n++) begin
      exp_rc[n] = 5'(rcv);
      if (n < 25) exp_k[n+1] = ref_update(exp_k[n], rcv);
      rcv = ((rcv << 1) | (((rcv >> 4) ^ (rcv >> 2)) & 1)) & 31;
    end
  endtask

  task automatic start_seq(input logic [79:0] mk);
    build_expected(mk);
    bus.iv_master_key = mk;
    @(negedge clk) bus.i_start = 1'b1;
    @(negedge clk) bus.i_start = 1'b0;
  endtask

  function automatic logic [79:0] rand_key();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_rk_ready = 1'b0;
    bus.iv_master_key = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0 || bus.o_rk_valid !== 1'b0 || bus.o_done !== 1'b0) begin
      fails++; $display("FAIL reset_flags: busy/valid/done=%b%b%b required 000", bus.o_busy, bus.o_rk_valid, bus.o_done); end
    checks++; if (bus.o_key_select !== 1'b1 || bus.ov_round !== 5'd0) begin
      fails++; $display("FAIL reset_sel_round: sel=%b round=%0d required 1/0", bus.o_key_select, bus.ov_round); end
    checks++; if (dut.rc !== 5'h01) begin
      fails++; $display("FAIL reset_rc: got %h required 01", dut.rc); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [4:0] rc_tab [6] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05};
    bus.i_rk_ready = 1'b1;
    start_seq(80'h0);
    checks++; if (bus.o_key_select !== 1'b0 || bus.o_busy !== 1'b1) begin
      fails++; $display("FAIL load_cycle: sel=%b busy=%b required 0/1", bus.o_key_select, bus.o_busy); end
    for (int n = 0; n < 26; n++) begin
      @(negedge clk);
      checks++; if (bus.o_rk_valid !== 1'b1 || bus.ov_round !== 5'(n)) begin
        fails++; $display("FAIL basic_round: valid=%b round=%0d required 1/%0d", bus.o_rk_valid, bus.ov_round, n); end
      checks++; if (bus.ov_round_key !== exp_k[n][63:0]) begin
        fails++; $display("FAIL basic_key K%0d: got %h required %h", n, bus.ov_round_key, exp_k[n][63:0]); end
      if (n == 0) begin
        checks++; if (bus.ov_round_key !== 64'h0) begin
          fails++; $display("FAIL basic_k0: got %h required 0", bus.ov_round_key); end
      end
      if (n == 1) begin
        checks++; if (bus.ov_round_key !== 64'h0000_0000_000F_000E) begin
          fails++; $display("FAIL basic_k1: got %h required 00000000000f000e", bus.ov_round_key); end
      end
      if (n < 6) begin
        checks++; if (dut.rc !== rc_tab[n]) begin
          fails++; $display("FAIL rc_trace %0d: got %h required %h", n, dut.rc, rc_tab[n]); end
      end
    end
    @(negedge clk);
    checks++; if (bus.o_done !== 1'b1 || bus.o_rk_valid !== 1'b0) begin
      fails++; $display("FAIL done_t28: done=%b valid=%b required 1/0", bus.o_done, bus.o_rk_valid); end
    @(negedge clk);
    checks++; if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0 || bus.ov_round_key !== exp_k[25][63:0]) begin
      fails++; $display("FAIL after_done: done=%b busy=%b key=%h required 0/0/%h", bus.o_done, bus.o_busy, bus.ov_round_key, exp_k[25][63:0]); end
  endtask

`ifndef RECT_KEY_AUTORUN_EN
  // ready_mode 0: random ready; 1: stall 3 cycles at round 4; 2: ready high with a start pulse at round 10
  task automatic test_handshake(input int ready_mode);
    int idx, stall, cyc;
    bit done_seen;
    logic [79:0] want2;
    idx = 0; stall = 0; cyc = 0; done_seen = 0;
    start_seq(rand_key());
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      case (ready_mode)
        0: bus.i_rk_ready = ($urandom_range(0, 3) != 0);
        1: bus.i_rk_ready = !(idx == 4 && stall < 3);
        default: bus.i_rk_ready = 1'b1;
      endcase
      bus.i_start = (ready_mode == 2 && idx == 10);
      #1;
      if (idx > 25) begin
        checks++; if (bus.o_done !== 1'b1) begin
          fails++; $display("FAIL hs%0d_done: got %b required 1", ready_mode, bus.o_done); end
        done_seen = 1;
      end else begin
        want2 = (bus.i_rk_ready && idx < 25) ? exp_k[idx+1] : exp_k[idx];
        checks++; if (bus.o_rk_valid !== 1'b1 || bus.ov_round !== 5'(idx) || bus.ov_round_key !== exp_k[idx][63:0]) begin
          fails++; $display("FAIL hs%0d_key: valid=%b round=%0d key=%h required 1/%0d/%h",
                            ready_mode, bus.o_rk_valid, bus.ov_round, bus.ov_round_key, idx, exp_k[idx][63:0]); end
        checks++; if (bus.ov_key_data2 !== want2) begin
          fails++; $display("FAIL hs%0d_data2: got %h required %h", ready_mode, bus.ov_key_data2, want2); end
        if (ready_mode == 1) begin
          checks++; if (dut.rc !== exp_rc[idx]) begin
            fails++; $display("FAIL hs1_rc: got %h required %h", dut.rc, exp_rc[idx]); end
        end
        if (bus.i_rk_ready) idx++;
        else stall++;
      end
    end
    bus.i_start = 1'b0;
    if (!done_seen) begin
      checks++; fails++; $display("FAIL hs%0d_timeout: idx=%0d required done", ready_mode, idx);
    end
    @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0) begin
      fails++; $display("FAIL hs%0d_idle: busy=%b done=%b required 0/0", ready_mode, bus.o_busy, bus.o_done); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [79:0] mk;
    mk = rand_key();
    bus.i_rk_ready = 1'b1;
    start_seq(mk);
    repeat (8) @(negedge clk);
    checks++; if (bus.ov_round !== 5'd7) begin
      fails++; $display("FAIL mid_round7: got %0d required 7", bus.ov_round); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_rk_valid !== 1'b0 || bus.ov_round !== 5'd0 || bus.o_busy !== 1'b0) begin
      fails++; $display("FAIL mid_reset: valid=%b round=%0d busy=%b required 0/0/0", bus.o_rk_valid, bus.ov_round, bus.o_busy); end
    rst = 1'b0;
    @(negedge clk);
    start_seq(mk);
    for (int n = 0; n < 26; n++) begin
      @(negedge clk);
      checks++; if (bus.ov_round !== 5'(n) || bus.ov_round_key !== exp_k[n][63:0]) begin
        fails++; $display("FAIL restart_key K%0d: round=%0d key=%h required %h", n, bus.ov_round, bus.ov_round_key, exp_k[n][63:0]); end
    end
    @(negedge clk);
    checks++; if (bus.o_done !== 1'b1) begin
      fails++; $display("FAIL restart_done: got %b required 1", bus.o_done); end
    @(negedge clk);
  endtask

`ifdef RECT_KEY_AUTORUN_EN
  task automatic test_autorun();
    bus.i_rk_ready = 1'b0;
    start_seq(rand_key());
    for (int n = 0; n < 26; n++) begin
      @(negedge clk);
      checks++; if (bus.o_rk_valid !== 1'b1 || bus.ov_round !== 5'(n) || bus.ov_round_key !== exp_k[n][63:0]) begin
        fails++; $display("FAIL autorun K%0d: round=%0d key=%h required %h", n, bus.ov_round, bus.ov_round_key, exp_k[n][63:0]); end
    end
    @(negedge clk);
    checks++; if (bus.o_done !== 1'b1) begin
      fails++; $display("FAIL autorun_done: got %b required 1", bus.o_done); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
`ifdef RECT_KEY_AUTORUN_EN
    test_autorun();
`else
    test_handshake(0);
    test_handshake(1);
    test_handshake(2);
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
